// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller:
// hex-to-segment table, segment bit positions and index-width helper.
package seg_scan_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;
   localparam int SEG_W = 7;

   localparam int NIB_W = 4;
   localparam int DIM_W = 4;

   // {g,f,e,d,c,b,a}, 1 = lit
   localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic int idx_width(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high segment pattern lookup.
module seg_hex_decode
   import seg_scan_pkg::*;
(
   input  logic [NIB_W-1:0] nibble,
   output logic [SEG_W-1:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous double buffering.
// Optional anode dimming when SEG_SCAN_DIM_EN is defined.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int DIV_W      = 16,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic                  load,
`ifdef SEG_SCAN_DIM_EN
   input  logic [DIM_W-1:0]      brightness,
`endif
   output logic [DIGITS-1:0]     an,
   output logic [SEG_W-1:0]      seg,
   output logic                  dp,
   output logic                  frame
);

   localparam int   IDX_W = idx_width(DIGITS);
   localparam logic POL   = (ACTIVE_LOW != 0);

   logic [DIV_W-1:0]    presc;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] pend_data, disp_data;
   logic [DIGITS-1:0]   pend_dp, pend_blank, disp_dp, disp_blank;
   logic                pend_v;

   logic tick, last_idx, boundary;

   assign tick     = &presc;
   assign last_idx = (idx == IDX_W'(DIGITS-1));
   assign boundary = tick && last_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         presc      <= '0;
         idx        <= '0;
         pend_v     <= 1'b0;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         disp_data  <= '0;
         disp_dp    <= '0;
         disp_blank <= '0;
      end else begin
         presc <= presc + 1'b1;
         if (tick)
            idx <= last_idx ? '0 : idx + 1'b1;

         if (load && !boundary) begin
            pend_data  <= data_in;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
            pend_v     <= 1'b1;
         end

         // a load landing on the boundary bypasses the pending stage
         if (boundary) begin
            pend_v <= 1'b0;
            if (load) begin
               disp_data  <= data_in;
               disp_dp    <= dp_in;
               disp_blank <= blank_in;
            end else if (pend_v) begin
               disp_data  <= pend_data;
               disp_dp    <= pend_dp;
               disp_blank <= pend_blank;
            end
         end
      end
   end

   logic [NIB_W-1:0] cur_nib;
   logic             cur_dp, cur_blank;

   always_comb begin
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nib   = disp_data[4*i +: 4];
            cur_dp    = disp_dp[i];
            cur_blank = disp_blank[i];
         end
      end
   end

   logic [SEG_W-1:0] seg_lit;

   seg_hex_decode u_dec (
      .nibble (cur_nib),
      .seg    (seg_lit)
   );

   logic              on_time;
   logic [DIGITS-1:0] an_on;
   logic [SEG_W-1:0]  seg_on;
   logic              dp_on;

   // first cycle of each slot is an anti-ghosting guard
   always_comb begin
`ifdef SEG_SCAN_DIM_EN
      on_time = (presc != '0) && (presc[DIV_W-1 -: DIM_W] <= brightness);
`else
      on_time = (presc != '0);
`endif
      an_on = '0;
      for (int i = 0; i < DIGITS; i++)
         an_on[i] = (idx == IDX_W'(i)) && on_time && !cur_blank;
      seg_on = cur_blank ? '0 : seg_lit;
      dp_on  = cur_dp && !cur_blank;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         an    <= {DIGITS{POL}};
         seg   <= {SEG_W{POL}};
         dp    <= POL;
         frame <= 1'b0;
      end else begin
         an    <= an_on  ^ {DIGITS{POL}};
         seg   <= seg_on ^ {SEG_W{POL}};
         dp    <= dp_on  ^ POL;
         frame <= boundary;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (DIGITS=4, DIV_W=4, ACTIVE_LOW=1).
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        load;
`ifdef SEG_SCAN_DIM_EN
   logic [3:0]  brightness = 4'd15;
`endif
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame;

   int n_cmp  = 0;
   int n_fail = 0;
   int k      = 0;
   int fcount = 0;
   int on_cnt;

   logic [3:0] an_exp  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] seg_1a3f[4] = '{7'h0E, 7'h30, 7'h08, 7'h79};
   logic [6:0] seg_5678[4] = '{7'h00, 7'h78, 7'h02, 7'h12};
   logic [6:0] seg_c0de[4] = '{7'h06, 7'h21, 7'h40, 7'h46};

   seg_scan_ctrl #(.DIGITS(4), .DIV_W(4), .ACTIVE_LOW(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .load       (load),
`ifdef SEG_SCAN_DIM_EN
      .brightness (brightness),
`endif
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame      (frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp, k);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      k++;
      @(negedge clk);
      if (frame === 1'b1) fcount++;
   endtask

   task automatic run_to(input int target);
      while (k < target) tick();
   endtask

   initial begin
      reset    = 1'b1;
      load     = 1'b0;
      data_in  = '0;
      dp_in    = '0;
      blank_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_an",    an,    4'b1111);
      check("rst_seg",   seg,   7'h7F);
      check("rst_dp",    dp,    1'b1);
      check("rst_frame", frame, 1'b0);

      reset = 1'b0;
      k = 0;
      tick();
      check("post_rst_guard_an", an,  4'b1111);
      check("post_rst_seg",      seg, 7'h40);
      tick();
      check("post_rst_an0", an,  4'b1110);
      check("post_rst_dp",  dp,  1'b1);

      // scan / decode of 1A3F
      data_in = 16'h1A3F; load = 1'b1;
      tick();
      load = 1'b0;
      run_to(63);
      check("frame_pre", frame, 1'b0);
      tick();
      check("frame_64", frame, 1'b1);
      fcount = 0;
      tick();
      check("commit_guard_an",  an,  4'b1111);
      check("commit_guard_seg", seg, 7'h0E);
      check("frame_65", frame, 1'b0);
      for (int d = 0; d < 4; d++) begin
         run_to(64 + 16*d + 9);
         check("scan_an",  an,  an_exp[d]);
         check("scan_seg", seg, seg_1a3f[d]);
         run_to(64 + 16*d + 16);
         check("slot_end_an", an, an_exp[d]);
         if (d < 3) begin
            tick();
            check("slot_guard_an", an, 4'b1111);
         end
      end
      check("frame_128", frame, 1'b1);
      check("frames_per_64", fcount, 1);

      on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (an === 4'b1110) on_cnt++;
      end
      check("duty_slot0", on_cnt, 15);

      // tear-free: two loads in one frame, last wins
      run_to(150);
      data_in = 16'h1234; load = 1'b1;
      tick();
      load = 1'b0;
      run_to(160);
      data_in = 16'h5678; load = 1'b1;
      tick();
      load = 1'b0;
      run_to(170);
      check("hold_d2_seg", seg, 7'h08);
      check("hold_d2_an",  an,  4'b1011);
      run_to(180);
      check("hold_d3_seg", seg, 7'h79);
      run_to(191);
      check("frame_191", frame, 1'b0);
      tick();
      check("frame_192", frame, 1'b1);
      for (int d = 0; d < 4; d++) begin
         run_to(192 + 16*d + 9);
         check("last_wins_seg", seg, seg_5678[d]);
         check("last_wins_an",  an,  an_exp[d]);
      end

      // load exactly on the boundary cycle
      run_to(255);
      data_in = 16'hC0DE; load = 1'b1;
      tick();
      load = 1'b0;
      check("bnd_frame", frame, 1'b1);
      fcount = 0;
      tick();
      check("bnd_frame_next", frame, 1'b0);
      check("bnd_guard_seg",  seg,   7'h06);
      for (int d = 0; d < 4; d++) begin
         run_to(256 + 16*d + 9);
         check("bnd_seg", seg, seg_c0de[d]);
      end
      run_to(320);
      check("bnd_single_pulse", fcount, 1);
      run_to(329);
      check("bnd_no_stale_commit", seg, 7'h06);

      // blank digit 2, dp on digit 0
      run_to(330);
      data_in = 16'h8888; dp_in = 4'b0001; blank_in = 4'b0100; load = 1'b1;
      tick();
      load = 1'b0;
      run_to(393);
      check("dp_d0_an",  an,  4'b1110);
      check("dp_d0_seg", seg, 7'h00);
      check("dp_d0_dp",  dp,  1'b0);
      run_to(409);
      check("dp_d1_an", an, 4'b1101);
      check("dp_d1_dp", dp, 1'b1);
      run_to(425);
      check("blank_d2_an",  an,  4'b1111);
      check("blank_d2_seg", seg, 7'h7F);
      check("blank_d2_dp",  dp,  1'b1);
      run_to(441);
      check("d3_an", an, 4'b0111);

      // reset mid-frame drops pending data
      data_in = 16'h2222; dp_in = '0; blank_in = '0; load = 1'b1;
      tick();
      load = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      check("mid_rst_an",    an,    4'b1111);
      check("mid_rst_seg",   seg,   7'h7F);
      check("mid_rst_dp",    dp,    1'b1);
      check("mid_rst_frame", frame, 1'b0);
      reset = 1'b0;
      k = 0;
      run_to(2);
      check("mid_rst_an0",  an,  4'b1110);
      check("mid_rst_seg0", seg, 7'h40);
      run_to(64);
      check("mid_rst_frame64", frame, 1'b1);
      run_to(73);
      check("pend_discarded_seg", seg, 7'h40);
      check("pend_discarded_an",  an,  4'b1110);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
